// File: rtl/pkt_pkg.sv
// Shared types for the packet router: beat format, packet types and router FSM states.
// Imported by the router top and its input FIFO.
package pkt_pkg;

  localparam int PORTS = 4;

  typedef enum logic [1:0] {
    DATA     = 2'd0,
    CONTROL  = 2'd1,
    RESPONSE = 2'd2,
    RESERVED = 2'd3
  } packet_type_t;

  typedef struct packed {
    logic [1:0]   dest;
    packet_type_t ptype;
    logic [7:0]   payload;
    logic         eop;
  } pkt_beat_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } router_state_t;

  function automatic logic [PORTS-1:0] port_onehot(input logic [1:0] port);
    logic [PORTS-1:0] v;
    v       = '0;
    v[port] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Show-ahead synchronous FIFO with asynchronous active-high reset.
// full_nxt exposes next-cycle fullness so the owner can register a ready flag.
module pkt_fifo
  import pkt_pkg::*;
#(
  parameter int WIDTH = $bits(pkt_beat_t),
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             full_nxt
);

  localparam int            AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // A full FIFO refuses writes even when a pop frees a slot in the same cycle.
  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rdata    = mem_q[rd_ptr_q];
  assign full_nxt = (count_d == FULL_CNT);

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
    else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the occupancy count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/packet_router.sv
// Packet router: buffers beats, steers whole packets to one of four ports by the
// first beat's dest, drops RESERVED packets and counts forwarded/dropped packets.
module packet_router
  import pkt_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_dest,
  input  logic [1:0]             in_type,
  input  logic [7:0]             in_payload,
  input  logic                   in_eop,
  output logic [PORTS-1:0]       out_valid,
  input  logic [PORTS-1:0]       out_ready,
  output logic [1:0]             out_type,
  output logic [7:0]             out_payload,
  output logic                   out_eop,
  output logic [PORTS*CNT_W-1:0] fwd_cnt,
  output logic [CNT_W-1:0]       drop_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  pkt_beat_t                   in_beat, head;
  logic [$bits(pkt_beat_t)-1:0] head_raw;
  logic                        push, pop;
  logic                        fifo_full, fifo_empty, fifo_full_nxt;
  logic                        in_ready_q;
  router_state_t               state_q, state_d;
  logic [1:0]                  port_q, port_d;
  logic [CNT_W-1:0]            fwd_cnt_q [PORTS];
  logic [CNT_W-1:0]            fwd_cnt_d [PORTS];
  logic [CNT_W-1:0]            drop_cnt_q, drop_cnt_d;

  assign in_beat  = '{dest: in_dest, ptype: packet_type_t'(in_type),
                      payload: in_payload, eop: in_eop};
  assign push     = in_valid && in_ready_q;
  assign head     = pkt_beat_t'(head_raw);
  assign in_ready = in_ready_q;
  assign drop_cnt = drop_cnt_q;

  pkt_fifo #(.WIDTH($bits(pkt_beat_t)), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .wdata    (in_beat),
    .pop      (pop),
    .rdata    (head_raw),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .full_nxt (fifo_full_nxt)
  );

  for (genvar p = 0; p < PORTS; p++) begin : g_fwd_cnt
    assign fwd_cnt[p*CNT_W +: CNT_W] = fwd_cnt_q[p];
  end

  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    fwd_cnt_d   = fwd_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    pop         = 1'b0;
    out_valid   = '0;
    out_type    = '0;
    out_payload = '0;
    out_eop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          port_d  = head.dest;
          state_d = (head.ptype == RESERVED) ? DROP : FWD;
        end
      end
      FWD: begin
        out_type    = head.ptype;
        out_payload = head.payload;
        out_eop     = head.eop;
        if (!fifo_empty) out_valid = port_onehot(port_q);
        // Only the selected port's ready is looked at, so unselected X cannot leak.
        pop = !fifo_empty && out_ready[port_q];
        if (pop && head.eop) begin
          fwd_cnt_d[port_q] = fwd_cnt_q[port_q] + CNT_ONE;
          state_d           = IDLE;
        end
      end
      DROP: begin
        pop = !fifo_empty;
        if (pop && head.eop) begin
          drop_cnt_d = drop_cnt_q + CNT_ONE;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      port_q     <= '0;
      in_ready_q <= 1'b0;
      fwd_cnt_q  <= '{default: '0};
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      port_q     <= port_d;
      in_ready_q <= !fifo_full_nxt;
      fwd_cnt_q  <= fwd_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_packet_router.sv
// Directed bench for packet_router: scoreboard of expected output beats filled at send time,
// drained by a negedge monitor; counters checked against a small reference model.
module tb_packet_router;
  import pkt_pkg::*;

  typedef struct packed {
    logic [1:0] port;
    logic [1:0] ptype;
    logic [7:0] payload;
    logic       eop;
  } exp_beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_dest, in_type;
  logic [7:0]  in_payload;
  logic        in_eop;
  logic [3:0]  out_valid, out_ready;
  logic [1:0]  out_type;
  logic [7:0]  out_payload;
  logic        out_eop;
  logic [63:0] fwd_cnt;
  logic [15:0] drop_cnt;

  int          n_cmp  = 0;
  int          n_fail = 0;
  exp_beat_t   sb[$];
  logic [15:0] exp_fwd [4];
  logic [15:0] exp_drop;
  bit          first_beat;
  logic [1:0]  cur_port;
  bit          cur_drop;
  bit          rand_ready = 1'b0;

  logic [3:0]  prev_valid, prev_ready;
  logic [10:0] prev_beat;

  packet_router #(.DEPTH(8), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_dest     (in_dest),
    .in_type     (in_type),
    .in_payload  (in_payload),
    .in_eop      (in_eop),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_type    (out_type),
    .out_payload (out_payload),
    .out_eop     (out_eop),
    .fwd_cnt     (fwd_cnt),
    .drop_cnt    (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 4'($urandom_range(0, 15));
  endtask

  task automatic model_clear();
    sb.delete();
    for (int p = 0; p < 4; p++) exp_fwd[p] = '0;
    exp_drop   = '0;
    first_beat = 1'b1;
    cur_port   = '0;
    cur_drop   = 1'b0;
  endtask

  task automatic model_beat(input logic [1:0] d, input logic [1:0] t,
                            input logic [7:0] pl, input logic e);
    if (first_beat) begin
      cur_port = d;
      cur_drop = (t == 2'(RESERVED));
    end
    if (!cur_drop) sb.push_back('{port: cur_port, ptype: t, payload: pl, eop: e});
    if (e) begin
      if (cur_drop) exp_drop = exp_drop + 16'd1;
      else          exp_fwd[cur_port] = exp_fwd[cur_port] + 16'd1;
    end
    first_beat = e;
  endtask

  task automatic send_beat(input logic [1:0] d, input logic [1:0] t,
                           input logic [7:0] pl, input logic e);
    bit acc = 1'b0;
    int n   = 0;
    in_valid = 1'b1; in_dest = d; in_type = t; in_payload = pl; in_eop = e;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("accept", acc, 1);
    if (acc) model_beat(d, t, pl, e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    check("drain", sb.size(), 0);
    tick();
    tick();
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_fwd_cnt"}, fwd_cnt, {exp_fwd[3], exp_fwd[2], exp_fwd[1], exp_fwd[0]});
    check({tag, "_drop_cnt"}, drop_cnt, exp_drop);
  endtask

  // Output monitor: one-hot, hold-while-stalled and in-order scoreboard comparison.
  always @(negedge clk) begin
    logic [1:0] obs_port;
    exp_beat_t  e;
    if (reset) begin
      prev_valid = '0;
      prev_ready = '0;
      prev_beat  = '0;
    end else begin
      if (prev_valid != '0 && (prev_valid & prev_ready) == '0) begin
        check("hold_valid", out_valid, prev_valid);
        check("hold_beat", {out_type, out_payload, out_eop}, prev_beat);
      end
      check("onehot", $onehot0(out_valid), 1);
      if ((out_valid & out_ready) != '0) begin
        obs_port = '0;
        for (int p = 0; p < 4; p++) if (out_valid[p]) obs_port = 2'(p);
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("beat", {obs_port, out_type, out_payload, out_eop}, e);
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_beat  = {out_type, out_payload, out_eop};
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_dest = '0; in_type = '0;
    in_payload = '0; in_eop = 1'b0; out_ready = 4'hF;
    model_clear();
    tick(); tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_shared", {out_type, out_payload, out_eop}, 0);
    check_counters("rst");
    reset = 1'b0;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // 1: single-beat DATA packet, two-cycle accept-to-offer latency.
    send_beat(2'd2, DATA, 8'h5A, 1'b1);
    check("t1_idle_gap", out_valid, 4'b0000);
    tick();
    check("t1_out_valid", out_valid, 4'b0100);
    check("t1_out_payload", out_payload, 8'h5A);
    drain();
    check_counters("t1");

    // 2: first beat routes the whole packet.
    send_beat(2'd1, CONTROL, 8'h11, 1'b0);
    send_beat(2'd3, DATA,    8'h12, 1'b0);
    send_beat(2'd3, DATA,    8'h13, 1'b1);
    drain();
    check_counters("t2");

    // 3: RESERVED packet dropped, following DATA packet delivered.
    send_beat(2'd0, RESERVED, 8'hA0, 1'b0);
    send_beat(2'd2, DATA,     8'hA1, 1'b1);
    send_beat(2'd0, DATA,     8'hB0, 1'b1);
    drain();
    check_counters("t3");

    // 4: backpressure on port 0 fills the FIFO; head holds stable.
    out_ready = 4'b1110;
    for (int i = 0; i < 8; i++) send_beat(2'd0, DATA, 8'(8'h40 + i), 1'b0);
    check("t4_in_ready_full", in_ready, 0);
    check("t4_out_valid", out_valid, 4'b0001);
    check("t4_payload", out_payload, 8'h40);
    tick(); tick(); tick();
    check("t4_payload_hold", out_payload, 8'h40);
    out_ready = 4'hF;
    send_beat(2'd0, DATA, 8'h48, 1'b0);
    send_beat(2'd0, DATA, 8'h49, 1'b1);
    drain();
    check_counters("t4");

    // 5: reset mid-packet; the remainder forms a new packet routed by beat 3.
    send_beat(2'd1, DATA, 8'h51, 1'b0);
    send_beat(2'd1, DATA, 8'h52, 1'b0);
    reset = 1'b1;
    model_clear();
    #1;
    check("t5_in_ready", in_ready, 0);
    check("t5_out_valid", out_valid, 0);
    check_counters("t5_rst");
    tick(); tick();
    reset = 1'b0;
    tick();
    check("t5_in_ready_rel", in_ready, 1);
    send_beat(2'd2, CONTROL, 8'h53, 1'b0);
    send_beat(2'd0, DATA,    8'h54, 1'b1);
    drain();
    check_counters("t5");

    // 6: back-to-back packets to every port under random downstream ready.
    reset = 1'b1;
    model_clear();
    tick();
    reset = 1'b0;
    tick();
    rand_ready = 1'b1;
    for (int p = 0; p < 4; p++) begin
      send_beat(2'(p), RESPONSE, 8'(8'h60 + 4 * p), 1'b0);
      send_beat(2'(3 - p), DATA, 8'(8'h61 + 4 * p), 1'b0);
      send_beat(2'(p), CONTROL,  8'(8'h62 + 4 * p), 1'b1);
    end
    drain();
    rand_ready = 1'b0;
    out_ready  = 4'hF;
    tick();
    check_counters("t6");

    // 7: exactly one idle bubble between two queued packets.
    out_ready = 4'h0;
    send_beat(2'd0, DATA,     8'h70, 1'b1);
    send_beat(2'd3, RESPONSE, 8'h71, 1'b1);
    check("t7_stalled", out_valid, 4'b0001);
    out_ready = 4'hF;
    tick();
    check("t7_bubble", out_valid, 4'b0000);
    tick();
    check("t7_next", out_valid, 4'b1000);
    check("t7_next_type", out_type, 2'(RESPONSE));
    drain();
    check_counters("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
